// File: rtl/button_pulse_gen.sv
// ---------------------------------------------------------------------------
// button_pulse_gen
//
// Turns a raw, bouncy, asynchronous pushbutton into clean single-cycle event
// pulses in the clk domain. The input is synchronized and then debounced.
// A small press/hold/repeat FSM then turns the debounced level into pulses.
// click_pulse drives the source input of a downstream pulse synchronizer.
// All pulses are one cycle wide and never adjacent to each other, so that
// synchronizer cannot merge them.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_in        in   raw button (asynchronous, bouncy)
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  one cycle when the debounced level rises
//   release_pulse out  one cycle when the debounced level falls
//   repeat_pulse  out  one cycle per auto-repeat tick while held
//   click_pulse   out  press_pulse | repeat_pulse, registered
// ---------------------------------------------------------------------------
module button_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned REPEAT_CYCLES     = 10000000,
    parameter int unsigned REPEAT_EN         = 1,
    parameter int unsigned BTN_ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic click_pulse
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                       LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HCNT_W   = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REPEAT_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    // Raw level of an untouched button. The synchronizer resets to this
    // value so that leaving reset never looks like a press.
    localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, then polarity normalisation
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic sync_pressed;

    // NOTE: sequential state is always assigned with <=, so every flop
    // samples the pre-edge values of its neighbours and the order of
    // statements inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= BTN_IDLE;
            sync2_q <= BTN_IDLE;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign sync_pressed = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // ------------------------------------------------------------------
    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples. Any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             deb_rise;
    logic             deb_fall;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            level_d = sync_pressed;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // These events are seen on the edge where the level flips. The FSM
    // therefore registers its pulse in the same cycle that btn_level
    // first shows the new value.
    assign deb_rise = level_d & ~level_q;
    assign deb_fall = ~level_d & level_q;

    // ------------------------------------------------------------------
    // Press / hold / auto-repeat FSM with registered pulse outputs
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic              press_q;
    logic              release_q;
    logic              repeat_q;
    logic              click_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            click_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (deb_rise) begin
                        press_q <= 1'b1;
                        click_q <= 1'b1;
                        hcnt_q  <= '0;
                        state_q <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    // A release is checked first, so it wins over a repeat
                    // that expires on the same edge.
                    if (deb_fall) begin
                        release_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (hcnt_q == LONG_LAST) begin
                            repeat_q <= 1'b1;
                            click_q  <= 1'b1;
                            hcnt_q   <= '0;
                            state_q  <= ST_HELD;
                        end else begin
                            hcnt_q <= hcnt_q + HCNT_ONE;
                        end
                    end
                end
                ST_HELD: begin
                    if (deb_fall) begin
                        release_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (hcnt_q == REP_LAST) begin
                        repeat_q <= 1'b1;
                        click_q  <= 1'b1;
                        hcnt_q   <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HCNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign click_pulse   = click_q;

endmodule
